// File: rtl/qbert_pkg.sv
// Shared types and constants for the Q*bert move sequencer.
package qbert_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    LAUNCH     = 3'd2,
    MOVING     = 3'd3,
    KO_HOLD    = 3'd4
  } seq_state_t;

  localparam logic [2:0] JMP_UL = 3'd1;
  localparam logic [2:0] JMP_UR = 3'd2;
  localparam logic [2:0] JMP_DL = 3'd3;
  localparam logic [2:0] JMP_DR = 3'd4;

  localparam int unsigned ST_PAUSE   = 1;
  localparam int unsigned JMP_STROBE = 3;

  // Only the four diagonal directions are legal moves.
  function automatic logic jump_valid(input logic [2:0] dir);
    return (dir >= JMP_UL) && (dir <= JMP_DR);
  endfunction

endpackage

// File: rtl/qbert_jump_fifo.sv
// Small synchronous FIFO of 3-bit jump directions; flush wins over push/pop.
module qbert_jump_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [2:0]               wdata,
  output logic [2:0]               head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qbert_move_sequencer.sv
// Frame-synchronous launcher of queued Q*bert jumps with pause/resume edge
// translation, knockout flush and a MOVING watchdog.
module qbert_move_sequencer
  import qbert_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     iEnable,
  input  logic                     iNewFrame,
  input  logic [7:0]               iSPI_jump,
  input  logic [7:0]               iSPI_game_status,
  input  logic                     done_move,
  input  logic [3:0]               KO_qb,
  output logic                     e_start_qb,
  output logic [2:0]               e_jump_qb,
  output logic                     e_pause_qb,
  output logic                     e_resume_qb,
  output logic                     oBusy,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic [CNT_W-1:0]         oDropCnt,
  output logic [CNT_W-1:0]         oRejCnt,
  output logic                     oTimeout,
  output logic [2:0]               oState
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  seq_state_t    state, state_d;
  logic          strobe_q, cap_vld, pause_q, first_q;
  logic [2:0]    cap_dir;
  logic [TW-1:0] tmo_cnt;
  logic          pop_c, push_c, tmo_hit_c, ko_c, dir_ok_c;
  logic [2:0]    head_c;
  logic          full_c, empty_c;
  logic          unused_bits;

  assign unused_bits = ^{iSPI_game_status[7:2], iSPI_game_status[0], iSPI_jump[7:4]};
  assign ko_c     = (KO_qb != 4'd0);
  assign dir_ok_c = jump_valid(cap_dir);
  assign push_c   = iEnable && cap_vld && dir_ok_c && !full_c;
  assign oState   = state;

  qbert_jump_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (!iEnable || ko_c),
    .wdata   (cap_dir),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (oLevel)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_d;
  end

  // Disable beats knockout, knockout beats every ordinary transition.
  always_comb begin
    state_d   = state;
    pop_c     = 1'b0;
    tmo_hit_c = 1'b0;
    if (!iEnable) begin
      state_d = IDLE;
    end else if (ko_c) begin
      state_d = KO_HOLD;
    end else begin
      case (state)
        IDLE:       if (!empty_c && !pause_q) state_d = WAIT_FRAME;
        WAIT_FRAME: if (iNewFrame && !pause_q) begin
                      pop_c   = 1'b1;
                      state_d = LAUNCH;
                    end
        LAUNCH:     state_d = MOVING;
        MOVING:     if (!first_q && done_move) begin
                      state_d = IDLE;
                    end else if (!pause_q && (tmo_cnt == TW'(TIMEOUT_CYC - 1))) begin
                      tmo_hit_c = 1'b1;
                      state_d   = IDLE;
                    end
        KO_HOLD:    state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      strobe_q    <= 1'b0;
      cap_vld     <= 1'b0;
      cap_dir     <= '0;
      pause_q     <= 1'b0;
      first_q     <= 1'b0;
      tmo_cnt     <= '0;
      e_start_qb  <= 1'b0;
      e_jump_qb   <= '0;
      e_pause_qb  <= 1'b0;
      e_resume_qb <= 1'b0;
      oBusy       <= 1'b0;
      oTimeout    <= 1'b0;
      oDropCnt    <= '0;
      oRejCnt     <= '0;
    end else begin
      strobe_q    <= iSPI_jump[JMP_STROBE];
      cap_vld     <= iSPI_jump[JMP_STROBE] && !strobe_q;
      cap_dir     <= iSPI_jump[2:0];
      pause_q     <= iSPI_game_status[ST_PAUSE];
      e_pause_qb  <= iSPI_game_status[ST_PAUSE] && !pause_q;
      e_resume_qb <= !iSPI_game_status[ST_PAUSE] && pause_q;
      first_q     <= (state == LAUNCH);
      e_start_qb  <= (state_d == LAUNCH);
      oBusy       <= (state_d == LAUNCH) || (state_d == MOVING) || (state_d == KO_HOLD);
      oTimeout    <= oTimeout || tmo_hit_c;
      if (pop_c) e_jump_qb <= head_c;
      // Watchdog counts unpaused MOVING cycles only.
      if (state == LAUNCH)
        tmo_cnt <= '0;
      else if (state == MOVING && !pause_q && !tmo_hit_c)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (iEnable && cap_vld) begin
        if (!dir_ok_c) begin
          if (oRejCnt != '1) oRejCnt <= oRejCnt + CNT_W'(1);
        end else if (full_c) begin
          if (oDropCnt != '1) oDropCnt <= oDropCnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/qbert_move_sequencer.md
Name: qbert_move_sequencer

Overview:
Frame-synchronous controller that sequences Q*bert moves for the Qbert_Map_Color datapath. It captures jump commands from the SPI jump byte into a small FIFO and launches each one on a frame boundary with an e_start_qb pulse. It waits for done_move before launching the next command and translates SPI game-status edges into e_pause_qb/e_resume_qb pulses. It sits between the SPI receive registers and the map/colour engine in the iCLK (LCD) domain, and replaces ad-hoc Nios writes of start, pause and resume.

Parameters:
DEPTH, 4, jump FIFO depth in entries (power of two, 2..16)
TIMEOUT_CYC, 2_000_000, max iCLK cycles in MOVING before abort (roughly 4 frames at 1056x525)
CNT_W, 8, width of the saturating drop and reject counters

Ports:
iCLK  in  1  LCD control clock, rising edge
iRST_n  in  1  asynchronous active-low reset
iEnable  in  1  sequencer enable (Avalon enable bit); low flushes the FIFO and forces IDLE
iNewFrame  in  1  one-cycle pulse at pixel (0,0) (oNewFrame)
iSPI_jump  in  8  [3]=request strobe level, [2:0]=direction code
iSPI_game_status  in  8  [1]=pause level; other bits ignored
done_move  in  1  level from engine, high when the current move has finished
KO_qb  in  4  non-zero means Q*bert is knocked out
e_start_qb  out  1  one-cycle move launch pulse
e_jump_qb  out  3  direction of the current or last move; stable from launch until the next launch
e_pause_qb  out  1  one-cycle pause pulse
e_resume_qb  out  1  one-cycle resume pulse
oBusy  out  1  high in LAUNCH, MOVING and KO_HOLD
oLevel  out  $clog2(DEPTH)+1  FIFO occupancy
oDropCnt  out  CNT_W  saturating count of requests dropped because the FIFO was full
oRejCnt  out  CNT_W  saturating count of requests with an invalid direction
oTimeout  out  1  sticky; set on MOVING timeout, cleared only by reset
oState  out  3  current FSM state encoding

Behaviour:
- Reset (async, iRST_n=0): all outputs 0, FIFO empty, FSM in IDLE, edge registers cleared to 0.
- Request capture: register iSPI_jump[3] and detect its 0->1 edge. One cycle after the edge, the direction is checked.
  - Codes 1..4 are valid and are pushed into the FIFO.
  - Codes 0 and 5..7 are not pushed; oRejCnt increments.
  - If the FIFO is full, the request is dropped and oDropCnt increments. The FIFO is never overwritten.
  - A push and a pop in the same cycle are both allowed; oLevel stays unchanged.
- Counters saturate at 2^CNT_W-1.
- Pause edges: register iSPI_game_status[1]. A 0->1 edge gives a one-cycle e_pause_qb; a 1->0 edge gives a one-cycle e_resume_qb. Both pulses come one cycle after the edge, independent of FSM state. While paused, no launch occurs and the MOVING timeout counter holds.
- FSM states: IDLE=0, WAIT_FRAME=1, LAUNCH=2, MOVING=3, KO_HOLD=4.
  - IDLE: if FIFO not empty, not paused and KO_qb==0, go to WAIT_FRAME.
  - WAIT_FRAME: on iNewFrame, pop the FIFO head into e_jump_qb and go to LAUNCH.
  - LAUNCH: e_start_qb=1 for exactly one cycle, clear the timeout counter, go to MOVING.
  - MOVING: the first cycle ignores done_move (blanking of stale done). After that, done_move=1 returns the FSM to IDLE. If the counter reaches TIMEOUT_CYC, set oTimeout and return to IDLE.
  - Any state: KO_qb!=0 flushes the FIFO (oLevel=0) and enters KO_HOLD. This has priority over every other transition except iEnable=0.
  - KO_HOLD: stay while KO_qb!=0; go to IDLE on the first cycle with KO_qb==0.
  - iEnable=0 in any state: synchronous flush and IDLE next cycle. Captures are discarded. Pause and resume pulses still pass through.
- Launch-to-launch spacing: at least one full frame, because each launch waits for iNewFrame.
- Latency: a request captured in an IDLE, unpaused, empty system launches on the first iNewFrame at least 2 cycles after the strobe edge. e_start_qb asserts in the cycle after that iNewFrame.
- Simultaneous events:
  - Capture edge and pop in the same cycle: both take effect.
  - iNewFrame arriving while paused in WAIT_FRAME: ignored; the FSM waits for the next frame after resume.

Decomposition:
- Shared package qbert_pkg holds:
  - the seq_state_t enum (IDLE..KO_HOLD, 3 bits);
  - direction constants JMP_UL=1, JMP_UR=2, JMP_DL=3, JMP_DR=4;
  - status bit index constants ST_PAUSE=1 and JMP_STROBE=3.
- One sub-module, qbert_jump_fifo: synchronous FIFO with parameter DEPTH and width 3. It provides push, pop, flush, full, empty and level, and shares iCLK/iRST_n.

Test Plan:
- Reset, then strobe direction 2, then iNewFrame -> e_start_qb pulses once with e_jump_qb=2 and oState=3. done_move=1 -> oState=0.
- Five strobes of direction 1 with DEPTH=4 and no frames -> oLevel=4, oDropCnt=1. Three strobes with codes 0, 5 and 7 -> oRejCnt=3, oLevel unchanged.
- Queue directions 3 then 4 -> launches occur on two distinct iNewFrame pulses, in order 3 then 4. There is no second launch before done_move.
- Set pause bit high, queue direction 1, send 3 frames, then clear pause -> e_pause_qb pulse, no launch while paused, e_resume_qb pulse, then launch on the next frame.
- KO_qb=4'h1 while in MOVING with 2 entries queued -> oLevel=0 and oState=4. KO_qb=0 -> oState=0 and no launch.
- Run with TIMEOUT_CYC=100 and never assert done_move -> after 100 cycles oTimeout=1 and oState=0. Assert iRST_n=0 mid-MOVING -> all outputs 0 asynchronously.
